ones_frame_accumulator: RTL and testbench
=========================================

// Module: ones_frame_accumulator
// PURPOSE
//  Streaming popcount stage: takes a stream of DATA_WIDTH-bit words with valid/ready and
//  frame delimiters, counts the set bits in each accepted word, and sums them over the frame.
//  When a frame closes it presents the frame total and the word count on a one-deep output
//  register with a valid/ready handshake.
//  Sits downstream of the combinational per-word ones counter.
// PARAMETERS
//  DATA_WIDTH  16  input word width; per-word count is $clog2(DATA_WIDTH)+1 bits
//  ACC_WIDTH   16  frame-total accumulator width (>= $clog2(DATA_WIDTH)+1)
//  WCNT_WIDTH  8   words-per-frame counter width
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           asynchronous reset, active-high
//  din          in   DATA_WIDTH  input word
//  din_valid    in   1           din/din_last valid
//  din_last     in   1           accepted word is the final word of the frame
//  din_ready    out  1           stage can accept a word
//  dout_total   out  ACC_WIDTH   sum of set bits over the frame
//  dout_words   out  WCNT_WIDTH  number of words in the frame (wraps mod 2^WCNT_WIDTH)
//  dout_ovf     out  1           frame total exceeded 2^ACC_WIDTH-1 at any point
//  dout_valid   out  1           result registers hold an unconsumed frame result
//  dout_ready   in   1           downstream accepts the result
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; acc=0, wcnt=0, ovf=0; dout_total=0,
//    dout_words=0, dout_ovf=0, dout_valid=0; din_ready=1 once reset is deasserted.
//  - Accept: a word is taken when din_valid & din_ready at the clk edge. pc = popcount(din),
//    zero-extended to ACC_WIDTH+1 before the add.
//  - FSM states:
//    IDLE: accepted word with !last -> acc=pc, wcnt=1 -> ACCUM.
//          Accepted word with last -> single-word frame -> HOLD.
//    ACCUM: accepted word adds: acc+=pc, wcnt+=1. Accepted word with last -> HOLD.
//    HOLD: dout_valid=1, din_ready=0. Handshake dout_valid&dout_ready -> clear acc/wcnt/ovf -> IDLE.
//  - din_ready = (state != HOLD). It is a registered-state decode; no combinational path
//    from dout_ready. A word is never taken in the cycle the result is popped.
//  - Latency: last word accepted at edge N -> dout_valid=1 and all result outputs final
//    after edge N. Minimum frame-to-frame spacing is 1 idle cycle per frame.
//  - Result outputs: loaded on entry to HOLD with the total including the last word.
//    They stay stable while dout_valid=1 && !dout_ready. After the pop they keep their
//    value (not cleared); dout_valid drops.
//  - Overflow: a sum above 2^ACC_WIDTH-1 sets ovf, which is sticky for the frame.
//  - Word count wraps silently mod 2^WCNT_WIDTH.
//  - din_valid low in ACCUM: hold state; no timeout.
//  - din_last with din_valid=0 is ignored.
//  - Reset mid-frame or in HOLD: partial frame / unpopped result is discarded; return to
//    reset values immediately.
// CONFIGURATION
//  ONES_ACC_SATURATE_EN defined:
//    - On overflow, acc clamps to 2^ACC_WIDTH-1 and stays there for the rest of the frame.
//    - dout_ovf is still set.
//  Undefined:
//    - acc wraps mod 2^ACC_WIDTH.
//    - dout_ovf flags the wrap.
// TESTING (DATA_WIDTH=16, ACC_WIDTH=8, WCNT_WIDTH=8)
//  - Single-word frame din=16'hF0F0, last=1 -> next cycle dout_valid=1, total=8, words=1, ovf=0.
//  - Frame 16'hFFFF,16'h0001,16'h0000(last), dout_ready=1 -> total=17, words=3; din_ready=0
//    for exactly the HOLD cycle.
//  - Backpressure: hold dout_ready=0 for 5 cycles after the frame ends -> outputs stable,
//    din_ready=0, input words not accepted. Pop -> IDLE.
//  - Overflow: 17 x 16'hFFFF (sum 272), last on the 17th word. Without macro -> total=16,
//    ovf=1. With ONES_ACC_SATURATE_EN -> total=255, ovf=1.
//  - Reset mid-frame after 2 words, then frame 16'h0003(last) -> total=2, words=1; no
//    residue from the prior frame.
//  - Gaps: din_valid toggling 1/0 across a 4-word frame of 16'h1111 -> total=16, words=4.

Source files
------------

// File: rtl/ones_frame_accumulator.sv
// Streaming popcount stage: sums set bits of accepted words over a frame and presents the
// frame total and word count through a one-deep valid/ready result register.
// Optional feature macro: ONES_ACC_SATURATE_EN (clamp the accumulator instead of wrapping).
module ones_frame_accumulator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned WCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  output logic [ACC_WIDTH-1:0]  dout_total,
  output logic [WCNT_WIDTH-1:0] dout_words,
  output logic                  dout_ovf,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int unsigned PC_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                  ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0]  total_q;
  logic [WCNT_WIDTH-1:0] words_q;
  logic                  res_ovf_q;

  logic [PC_WIDTH-1:0]   pc;
  logic                  accept;
  logic                  load_res;

  logic [ACC_WIDTH-1:0]  base_acc;
  logic [WCNT_WIDTH-1:0] base_wcnt;
  logic                  base_ovf;
  logic [ACC_WIDTH:0]    sum;
  logic                  sum_ovf;
  logic [ACC_WIDTH-1:0]  acc_upd;
  logic [WCNT_WIDTH-1:0] wcnt_upd;
  logic                  ovf_upd;

  always_comb begin
    pc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pc = pc + PC_WIDTH'(din[i]);
    end
  end

  assign din_ready  = (state_q != StHold);
  assign dout_valid = (state_q == StHold);
  assign accept     = din_valid & din_ready;

  // A frame that starts in IDLE never sees leftover accumulator contents.
  always_comb begin
    base_acc  = acc_q;
    base_wcnt = wcnt_q;
    base_ovf  = ovf_q;
    if (state_q == StIdle) begin
      base_acc  = '0;
      base_wcnt = '0;
      base_ovf  = 1'b0;
    end
  end

  assign sum      = {1'b0, base_acc} + (ACC_WIDTH + 1)'(pc);
  assign sum_ovf  = sum[ACC_WIDTH];
  assign ovf_upd  = base_ovf | sum_ovf;
  assign wcnt_upd = base_wcnt + WCNT_WIDTH'(1);

`ifdef ONES_ACC_SATURATE_EN
  // Once clamped, the accumulator stays at full scale for the rest of the frame.
  assign acc_upd = ovf_upd ? ACC_MAX : sum[ACC_WIDTH-1:0];
`else
  assign acc_upd = sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    wcnt_d   = wcnt_q;
    ovf_d    = ovf_q;
    load_res = 1'b0;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          acc_d  = acc_upd;
          wcnt_d = wcnt_upd;
          ovf_d  = ovf_upd;
          if (din_last) begin
            state_d  = StHold;
            load_res = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StHold: begin
        if (dout_ready) begin
          acc_d   = '0;
          wcnt_d  = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result registers keep their value after the pop; only dout_valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q   <= '0;
      words_q   <= '0;
      res_ovf_q <= 1'b0;
    end else if (load_res) begin
      total_q   <= acc_upd;
      words_q   <= wcnt_upd;
      res_ovf_q <= ovf_upd;
    end
  end

  assign dout_total = total_q;
  assign dout_words = words_q;
  assign dout_ovf   = res_ovf_q;

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed plus randomized bench for ones_frame_accumulator (DATA 16, ACC 8, WCNT 8);
// expected results come from a frame-level arithmetic model.
module tb_ones_frame_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic        din_last;
  logic        din_ready;
  logic [7:0]  dout_total;
  logic [7:0]  dout_words;
  logic        dout_ovf;
  logic        dout_valid;
  logic        dout_ready;

  int checks = 0;
  int errors = 0;

  // Frame-level model state.
  int          m_sum   = 0;
  int          m_words = 0;
  logic [7:0]  exp_total;
  logic [7:0]  exp_words;
  logic        exp_ovf;

  ones_frame_accumulator #(
    .DATA_WIDTH(16),
    .ACC_WIDTH (8),
    .WCNT_WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .dout_total(dout_total),
    .dout_words(dout_words),
    .dout_ovf  (dout_ovf),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_total(input int s);
`ifdef ONES_ACC_SATURATE_EN
    return (s > 255) ? 8'hFF : 8'(s);
`else
    return 8'(s % 256);
`endif
  endfunction

  // Offer one word at a negedge; returns at the negedge after it was taken.
  task automatic send(input logic [15:0] w, input logic last);
    bit rdy;
    int n;
    n = 0;
    din = w;
    din_last = last;
    din_valid = 1'b1;
    forever begin
      rdy = din_ready;
      @(posedge clk);
      if (rdy || n >= 64) break;
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    din_valid = 1'b0;
    din_last = 1'b0;
    chk("din_accept", rdy, 1);
    if (rdy) begin
      m_sum += $countones(w);
      m_words++;
      if (last) begin
        exp_total = ref_total(m_sum);
        exp_words = 8'(m_words % 256);
        exp_ovf   = (m_sum > 255);
        m_sum = 0;
        m_words = 0;
      end
    end
  endtask

  task automatic expect_result(input string tag, input logic [7:0] t, input logic [7:0] w,
                               input logic o);
    chk({tag, "_valid"}, dout_valid, 1);
    chk({tag, "_din_ready"}, din_ready, 0);
    chk({tag, "_total"}, dout_total, t);
    chk({tag, "_words"}, dout_words, w);
    chk({tag, "_ovf"}, dout_ovf, o);
  endtask

  task automatic pop(input string tag, input logic [7:0] t);
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
    chk({tag, "_pop_valid"}, dout_valid, 0);
    chk({tag, "_pop_din_ready"}, din_ready, 1);
    chk({tag, "_pop_total_kept"}, dout_total, t);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_total"}, dout_total, 0);
    chk({tag, "_words"}, dout_words, 0);
    chk({tag, "_ovf"}, dout_ovf, 0);
  endtask

  initial begin
    reset = 1'b1;
    din = '0;
    din_valid = 1'b0;
    din_last = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("reset_din_ready", din_ready, 1);

    // Single-word frame.
    send(16'hF0F0, 1'b1);
    expect_result("single", 8'd8, 8'd1, 1'b0);
    pop("single", 8'd8);

    // Three-word frame with downstream always ready: HOLD lasts one cycle.
    dout_ready = 1'b1;
    send(16'hFFFF, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0000, 1'b1);
    expect_result("three", 8'd17, 8'd3, 1'b0);
    pop("three", 8'd17);

    // Backpressure: words offered during HOLD must be ignored.
    send(16'h00FF, 1'b0);
    send(16'h0F00, 1'b1);
    din = 16'hFFFF;
    din_valid = 1'b1;
    din_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      expect_result("bp", 8'd12, 8'd2, 1'b0);
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    pop("bp", 8'd12);
    send(16'h0101, 1'b1);
    expect_result("after_bp", 8'd2, 8'd1, 1'b0);
    pop("after_bp", 8'd2);

    // Overflow: 17 full words, sum 272.
    for (int i = 0; i < 17; i++) send(16'hFFFF, i == 16);
`ifdef ONES_ACC_SATURATE_EN
    expect_result("ovf", 8'd255, 8'd17, 1'b1);
    pop("ovf", 8'd255);
`else
    expect_result("ovf", 8'd16, 8'd17, 1'b1);
    pop("ovf", 8'd16);
`endif

    // Reset mid-frame after two words, then asynchronous clear is visible at once.
    send(16'hFFFF, 1'b0);
    send(16'h7777, 1'b0);
    #2 reset = 1'b1;
    #1 check_zero("mid_reset");
    m_sum = 0;
    m_words = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_din_ready", din_ready, 1);
    send(16'h0003, 1'b1);
    expect_result("post_reset", 8'd2, 8'd1, 1'b0);
    pop("post_reset", 8'd2);

    // Gaps between words.
    for (int i = 0; i < 4; i++) begin
      send(16'h1111, i == 3);
      if (i != 3) @(negedge clk);
    end
    expect_result("gaps", 8'd16, 8'd4, 1'b0);
    pop("gaps", 8'd16);

    // Randomized frames against the model.
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        logic [15:0] w;
        w = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(w, i == len - 1);
      end
      expect_result("rnd", exp_total, exp_words, exp_ovf);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        expect_result("rnd_stall", exp_total, exp_words, exp_ovf);
      end
      pop("rnd", exp_total);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
